// File: rtl/platform_collider.sv
// Platform table plus sequential collision scanner: one table entry is tested per clock
// against the latched sprite box, keeping the topmost hit.
module platform_collider #(
  parameter int NUM_PLAT = 8,
  parameter int X_W      = 11,
  parameter int Y_W      = 10,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 50,
  parameter int TOL      = 4,
  localparam int IDX_W   = $clog2(NUM_PLAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [X_W-1:0]   cfg_x_start,
  input  logic [X_W-1:0]   cfg_x_end,
  input  logic [Y_W-1:0]   cfg_y_coll,
  input  logic             req,
  input  logic [X_W-1:0]   obj_x,
  input  logic [Y_W-1:0]   obj_y,
  input  logic             obj_falling,
  output logic             busy,
  output logic             done,
  output logic             on_plat,
  output logic [IDX_W-1:0] plat_idx,
  output logic [Y_W-1:0]   snap_y
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic               en_q  [NUM_PLAT];
  logic               en_d  [NUM_PLAT];
  logic [X_W-1:0]     xs_q  [NUM_PLAT];
  logic [X_W-1:0]     xs_d  [NUM_PLAT];
  logic [X_W-1:0]     xe_q  [NUM_PLAT];
  logic [X_W-1:0]     xe_d  [NUM_PLAT];
  logic [Y_W-1:0]     yc_q  [NUM_PLAT];
  logic [Y_W-1:0]     yc_d  [NUM_PLAT];

  logic [X_W-1:0]     ox_q, ox_d;
  logic [Y_W-1:0]     oy_q, oy_d;
  logic               fall_q, fall_d;
  logic [IDX_W-1:0]   scan_q, scan_d;
  logic               best_hit_q, best_hit_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic [Y_W-1:0]     best_y_q, best_y_d;
  logic               on_plat_q, on_plat_d;
  logic [IDX_W-1:0]   plat_idx_q, plat_idx_d;
  logic [Y_W-1:0]     snap_y_q, snap_y_d;

  logic [X_W:0]       obj_right;
  logic [Y_W:0]       feet;
  logic [Y_W:0]       line_bot;
  logic               hit;
  logic               take;
  logic               n_hit;
  logic [IDX_W-1:0]   n_idx;
  logic [Y_W-1:0]     n_y;

  // Geometry of the entry under the scan pointer; sums are one bit wider so they never wrap.
  always_comb begin
    obj_right = {1'b0, ox_q} + (X_W+1)'(SPRITE_W);
    feet      = {1'b0, oy_q} + (Y_W+1)'(SPRITE_H);
    line_bot  = {1'b0, yc_q[scan_q]} + (Y_W+1)'(TOL);
    hit = en_q[scan_q] && fall_q
       && (obj_right > {1'b0, xs_q[scan_q]})
       && (ox_q < xe_q[scan_q])
       && (feet >= {1'b0, yc_q[scan_q]})
       && (feet <= line_bot);
    // Strictly smaller line wins, so ties keep the lower index.
    take  = hit && (!best_hit_q || (yc_q[scan_q] < best_y_q));
    n_hit = best_hit_q | take;
    n_idx = take ? scan_q : best_idx_q;
    n_y   = take ? yc_q[scan_q] : best_y_q;
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    xs_d       = xs_q;
    xe_d       = xe_q;
    yc_d       = yc_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    fall_d     = fall_q;
    scan_d     = scan_q;
    best_hit_d = best_hit_q;
    best_idx_d = best_idx_q;
    best_y_d   = best_y_q;
    on_plat_d  = on_plat_q;
    plat_idx_d = plat_idx_q;
    snap_y_d   = snap_y_q;

    if (cfg_we && (state_q != SCAN) && (int'(cfg_idx) < NUM_PLAT)) begin
      en_d[cfg_idx] = cfg_en;
      xs_d[cfg_idx] = cfg_x_start;
      xe_d[cfg_idx] = cfg_x_end;
      yc_d[cfg_idx] = cfg_y_coll;
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          ox_d       = obj_x;
          oy_d       = obj_y;
          fall_d     = obj_falling;
          scan_d     = '0;
          best_hit_d = 1'b0;
          best_idx_d = '0;
          best_y_d   = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        best_hit_d = n_hit;
        best_idx_d = n_idx;
        best_y_d   = n_y;
        scan_d     = scan_q + 1'b1;
        if (scan_q == IDX_W'(NUM_PLAT-1)) begin
          state_d    = DONE;
          on_plat_d  = n_hit;
          plat_idx_d = n_hit ? n_idx : '0;
          if (!n_hit)
            snap_y_d = oy_q;
          else if ({1'b0, n_y} < (Y_W+1)'(SPRITE_H))
            snap_y_d = '0;
          else
            snap_y_d = n_y - Y_W'(SPRITE_H);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      en_q       <= '{default: '0};
      xs_q       <= '{default: '0};
      xe_q       <= '{default: '0};
      yc_q       <= '{default: '0};
      ox_q       <= '0;
      oy_q       <= '0;
      fall_q     <= 1'b0;
      scan_q     <= '0;
      best_hit_q <= 1'b0;
      best_idx_q <= '0;
      best_y_q   <= '0;
      on_plat_q  <= 1'b0;
      plat_idx_q <= '0;
      snap_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      xs_q       <= xs_d;
      xe_q       <= xe_d;
      yc_q       <= yc_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      fall_q     <= fall_d;
      scan_q     <= scan_d;
      best_hit_q <= best_hit_d;
      best_idx_q <= best_idx_d;
      best_y_q   <= best_y_d;
      on_plat_q  <= on_plat_d;
      plat_idx_q <= plat_idx_d;
      snap_y_q   <= snap_y_d;
    end
  end

  assign busy     = (state_q == SCAN);
  assign done     = (state_q == DONE);
  assign on_plat  = on_plat_q;
  assign plat_idx = plat_idx_q;
  assign snap_y   = snap_y_q;

endmodule

// File: tb/tb_platform_collider.sv
// Directed bench for platform_collider: landing, tolerance and edge boundaries,
// priority, gating, busy-time interference and reset during a scan.
module tb_platform_collider;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic        cfg_en;
  logic [10:0] cfg_x_start;
  logic [10:0] cfg_x_end;
  logic [9:0]  cfg_y_coll;
  logic        req;
  logic [10:0] obj_x;
  logic [9:0]  obj_y;
  logic        obj_falling;
  logic        busy;
  logic        done;
  logic        on_plat;
  logic [2:0]  plat_idx;
  logic [9:0]  snap_y;

  int checks   = 0;
  int failures = 0;
  int lat;
  int ndone;

  platform_collider #(
    .NUM_PLAT(8), .X_W(11), .Y_W(10), .SPRITE_W(32), .SPRITE_H(50), .TOL(4)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_x_start(cfg_x_start), .cfg_x_end(cfg_x_end), .cfg_y_coll(cfg_y_coll),
    .req(req), .obj_x(obj_x), .obj_y(obj_y), .obj_falling(obj_falling),
    .busy(busy), .done(done), .on_plat(on_plat), .plat_idx(plat_idx), .snap_y(snap_y)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_entry(input logic [2:0] idx, input logic en, input logic [10:0] xs,
                             input logic [10:0] xe, input logic [9:0] yc);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en;
    cfg_x_start = xs; cfg_x_end = xe; cfg_y_coll = yc;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Issues a request and returns at the negedge of the done cycle (lat = cycle number, 0 on timeout).
  task automatic do_scan(input logic [10:0] x, input logic [9:0] y, input logic f, output int cyc);
    @(negedge clk);
    obj_x = x; obj_y = y; obj_falling = f; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = 0;
  endtask

  task automatic scan_expect(input string tag, input logic [10:0] x, input logic [9:0] y,
                             input logic f, input logic eon, input logic [2:0] eidx,
                             input logic [9:0] esnap);
    int c;
    do_scan(x, y, f, c);
    check_eq({tag, ".lat"}, c, 9);
    check_eq({tag, ".on"}, on_plat, eon);
    check_eq({tag, ".idx"}, plat_idx, eidx);
    check_eq({tag, ".snap"}, snap_y, esnap);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_x_start = '0; cfg_x_end = '0; cfg_y_coll = '0;
    req = 1'b0; obj_x = '0; obj_y = '0; obj_falling = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.on", on_plat, 0);
    check_eq("rst.idx", plat_idx, 0);
    check_eq("rst.snap", snap_y, 0);

    // Basic landing with busy/done timing.
    write_entry(3'd0, 1'b1, 11'd180, 11'd650, 10'd600);
    @(negedge clk);
    obj_x = 11'd300; obj_y = 10'd552; obj_falling = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check_eq("basic.busy1", busy, 1);
    lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check_eq("basic.lat", lat, 9);
    check_eq("basic.busy_done", busy, 0);
    check_eq("basic.on", on_plat, 1);
    check_eq("basic.idx", plat_idx, 0);
    check_eq("basic.snap", snap_y, 550);
    @(negedge clk);
    check_eq("basic.done_pulse", done, 0);
    check_eq("basic.hold", snap_y, 550);

    scan_expect("tol550", 11'd300, 10'd550, 1'b1, 1'b1, 3'd0, 10'd550);
    scan_expect("tol554", 11'd300, 10'd554, 1'b1, 1'b1, 3'd0, 10'd550);
    scan_expect("tol555", 11'd300, 10'd555, 1'b1, 1'b0, 3'd0, 10'd555);
    scan_expect("tol549", 11'd300, 10'd549, 1'b1, 1'b0, 3'd0, 10'd549);

    scan_expect("x148", 11'd148, 10'd552, 1'b1, 1'b0, 3'd0, 10'd552);
    scan_expect("x149", 11'd149, 10'd552, 1'b1, 1'b1, 3'd0, 10'd550);
    scan_expect("x649", 11'd649, 10'd552, 1'b1, 1'b1, 3'd0, 10'd550);
    scan_expect("x650", 11'd650, 10'd552, 1'b1, 1'b0, 3'd0, 10'd552);

    write_entry(3'd2, 1'b1, 11'd0, 11'd250, 10'd460);
    write_entry(3'd3, 1'b1, 11'd200, 11'd300, 10'd458);
    scan_expect("prio.top", 11'd210, 10'd411, 1'b1, 1'b1, 3'd3, 10'd408);
    write_entry(3'd3, 1'b1, 11'd200, 11'd300, 10'd460);
    scan_expect("prio.tie", 11'd210, 10'd411, 1'b1, 1'b1, 3'd2, 10'd410);

    scan_expect("rising", 11'd210, 10'd411, 1'b0, 1'b0, 3'd0, 10'd411);

    write_entry(3'd5, 1'b0, 11'd1000, 11'd1100, 10'd300);
    scan_expect("dis", 11'd1010, 10'd250, 1'b1, 1'b0, 3'd0, 10'd250);
    write_entry(3'd5, 1'b1, 11'd1000, 11'd1100, 10'd300);
    scan_expect("ena", 11'd1010, 10'd250, 1'b1, 1'b1, 3'd5, 10'd250);

    // Write and request during busy must both be dropped.
    @(negedge clk);
    obj_x = 11'd300; obj_y = 10'd552; obj_falling = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3) begin
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b1;
        cfg_x_start = 11'd180; cfg_x_end = 11'd650; cfg_y_coll = 10'd700;
        obj_y = 10'd652; req = 1'b1;
      end
      if (c == 4) begin cfg_we = 1'b0; req = 1'b0; end
      if (done) begin
        ndone++;
        check_eq("busyw.on", on_plat, 1);
        check_eq("busyw.snap", snap_y, 550);
      end
      @(negedge clk);
    end
    check_eq("busyw.ndone", ndone, 1);
    scan_expect("busyw.table", 11'd300, 10'd552, 1'b1, 1'b1, 3'd0, 10'd550);

    // Reset in scan cycle 4.
    @(negedge clk);
    obj_x = 11'd300; obj_y = 10'd552; obj_falling = 1'b1; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check_eq("mrst.ndone", ndone, 0);
    check_eq("mrst.busy", busy, 0);
    check_eq("mrst.on", on_plat, 0);
    check_eq("mrst.idx", plat_idx, 0);
    check_eq("mrst.snap", snap_y, 0);
    scan_expect("mrst.cleared", 11'd300, 10'd552, 1'b1, 1'b0, 3'd0, 10'd552);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/platform_collider.md
Name: platform_collider

Overview:
- Runtime-configurable platform table of NUM_PLAT entries, each holding x span, collision line and an enable bit. Replaces fixed per-platform constants.
- On request, scans the table one entry per clock against a sprite bounding box and reports whether the sprite lands on a platform, which platform, and the snapped sprite y.
- Sits between the character motion logic (requester, once per frame) and the map/level loader (table writer).

Parameters:
- NUM_PLAT, 8, number of platform table entries (>=2).
- X_W, 11, width of x coordinates.
- Y_W, 10, width of y coordinates.
- SPRITE_W, 32, sprite width in pixels.
- SPRITE_H, 50, sprite height in pixels.
- TOL, 4, landing tolerance below the collision line in pixels.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  table write strobe
- cfg_idx  in  $clog2(NUM_PLAT)  entry to write
- cfg_en  in  1  entry enable
- cfg_x_start  in  X_W  platform left x (inclusive)
- cfg_x_end  in  X_W  platform right x (exclusive)
- cfg_y_coll  in  Y_W  platform collision line y
- req  in  1  start scan (sampled in IDLE only)
- obj_x  in  X_W  sprite top-left x
- obj_y  in  Y_W  sprite top-left y
- obj_falling  in  1  1 = vertical velocity downward or zero
- busy  out  1  scan in progress
- done  out  1  one-cycle result strobe
- on_plat  out  1  landed on an enabled platform
- plat_idx  out  $clog2(NUM_PLAT)  index of the landed platform
- snap_y  out  Y_W  corrected sprite top-left y

Behaviour:
- Reset (one cycle with rst=1, any state): all entries en=0 and coords 0; FSM to IDLE; busy=0, done=0, on_plat=0, plat_idx=0, snap_y=0. A scan interrupted by reset never asserts done.
- Table write: when cfg_we=1 and busy=0, the entry at cfg_idx takes all cfg_* fields at the clock edge. Writes while busy=1 are ignored. cfg_idx >= NUM_PLAT is ignored.
- FSM states and transitions:
  - IDLE: on req=1, latch obj_x, obj_y and obj_falling; clear best-hit; scan index to 0; go to SCAN. busy=1 from the next cycle.
  - SCAN: evaluate one entry per cycle (entry k in scan cycle k). After entry NUM_PLAT-1, go to DONE.
  - DONE: done=1 for exactly one cycle; result outputs update in the same cycle; busy=0; go to IDLE.
- A req while busy is ignored (not queued).
- Latency: req sampled at edge 0 gives done high in cycle NUM_PLAT+1 (9 for defaults). The next req is accepted in the cycle after done.
- Hit condition for entry k (all terms must hold):
  - en=1 and latched obj_falling=1;
  - obj_x+SPRITE_W > x_start and obj_x < x_end;
  - feet = obj_y+SPRITE_H satisfies y_coll <= feet <= y_coll+TOL.
- Arithmetic widths: all sums are computed at width+1 bits, so there is no wrap-around.
- Selection among hits:
  - Choose the smallest y_coll (topmost platform).
  - On equal y_coll, choose the lowest index: a later entry replaces the best only if its y_coll is strictly smaller.
- Results:
  - Hit: on_plat=1, plat_idx=best, snap_y=y_coll-SPRITE_H. If y_coll < SPRITE_H, snap_y=0.
  - No hit: on_plat=0, plat_idx=0, snap_y=latched obj_y.
- Result outputs hold their value until the next DONE or reset.
- The latched inputs make the scan immune to obj_* changes during SCAN.

Test Plan:
- Basic landing: entry0 = en, x 180..650, y 600; obj_x=300, obj_y=552, falling, req -> done in cycle 9; on_plat=1, plat_idx=0, snap_y=550.
- Tolerance boundaries, same entry0:
  - obj_y=550 (feet 600) -> hit; obj_y=554 (feet 604) -> hit;
  - obj_y=555 (feet 605) -> miss, snap_y=555; obj_y=549 (feet 599) -> miss.
- Horizontal edges, entry0: obj_x=148 -> miss; obj_x=149 -> hit; obj_x=649 -> hit; obj_x=650 -> miss.
- Priority:
  - entry2 = x 0..250, y 460; entry3 = x 200..300, y 458; obj_x=210, obj_y=411 (feet 461) -> plat_idx=3, snap_y=408.
  - Then set entry3 y=460 -> plat_idx=2 (tie goes to lowest index).
- Gating:
  - obj_falling=0 on a geometric hit -> on_plat=0.
  - Entry with en=0 -> never hit.
  - cfg_we and req while busy -> ignored; table and results unchanged, exactly one done.
- Reset mid-scan: rst at scan cycle 4 -> no done; all outputs 0; table cleared. A subsequent req with the basic-landing geometry -> on_plat=0.
